rysy_mem_resp: RTL
==================

RYSY_MEM_RESP -- requirements
Module: rysy_mem_resp

Interface
REQ-001 Parameter REG_LEN, 32, data and address width in bits.
REQ-002 Parameter MEM_DEPTH, 1024, RAM depth in 32-bit words; the RAM occupies byte addresses 0x0000_0000-0x0000_0FFF.
REQ-003 Parameter IO_BASE, 32'h0001_0000, base address of the 16-byte register window.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 addr  input  REG_LEN  byte address from the core; addr[1:0] ignored.
REQ-007 wdata  input  REG_LEN  write data from the core, byte lanes aligned to be.
REQ-008 we  input  1  write strobe from the core.
REQ-009 be  input  4  byte enables; be[n] selects wdata[8n+7:8n].
REQ-010 rdata  output  REG_LEN  registered read data to the core.
REQ-011 gpio_out  output  REG_LEN  GPIO output register contents.
REQ-012 irq  output  1  timer-match flag, level.

Function
REQ-013 Decode: RAM when addr[31:12]==0, word index addr[11:2]; REG when addr[31:4]==IO_BASE[31:4], register index addr[3:2]; otherwise UNMAPPED.
REQ-014 Reads occur every cycle with no request signal; rdata at edge N+1 reflects addr sampled at edge N (1-cycle latency).
REQ-015 Write occurs at the edge where we=1; only lanes with be[n]=1 update; we=1 with be=0 writes nothing.
REQ-016 RAM read and write to the same word in the same cycle return the old (pre-write) word: read-first.
REQ-017 Register map: 0x0 GPIO (RW), 0x4 TIMER (RW), 0x8 CMP (RW), 0xC STATUS (bit0 = MATCH; reads return {31'b0, MATCH}; writing 1 to bit0 clears MATCH).
REQ-018 Register reads follow the same 1-cycle latency and read-first rule as the RAM.
REQ-019 UNMAPPED reads return 0; UNMAPPED writes have no effect.
REQ-020 TIMER increments by 1 every cycle, modulo 2^32 (0xFFFF_FFFF -> 0x0000_0000).
REQ-021 A TIMER write in a cycle loads the byte-merged value and suppresses the increment that cycle.
REQ-022 MATCH is set at the edge following any cycle in which TIMER == CMP (pre-increment value).
REQ-023 Set has priority over clear: a W1C write in the same cycle as a set condition leaves MATCH=1.
REQ-024 irq = MATCH, driven directly from the flop with no combinational path from inputs.
REQ-025 gpio_out = GPIO register.

Reset
REQ-026 While rst=0: rdata=0, gpio_out=0, TIMER=0, CMP=32'hFFFF_FFFF, MATCH=0, irq=0; takes effect immediately, independent of clk.
REQ-027 RAM contents are not reset and are preserved across reset.
REQ-028 A write coincident with reset assertion is discarded for registers; RAM state after it is unspecified.
REQ-029 After rst deasserts, TIMER first increments at the first rising edge of clk.

Verification
REQ-030 Write 0xDEADBEEF to RAM 0x10 with be=1111, then read 0x10 -> rdata=0xDEADBEEF one cycle after addr is presented.
REQ-031 Write 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF -> read 0xDEADBEAA; then we=1, be=0 -> word unchanged.
REQ-032 In one cycle, write 0x11111111 and read 0x20, which holds 0x22222222 -> rdata=0x22222222; the next read returns 0x11111111.
REQ-033 Write TIMER=0xFFFF_FFFE and CMP=0 -> TIMER reads 0xFFFF_FFFF then 0, and irq rises one cycle after TIMER=0; writing 1 to STATUS lowers irq next edge; a W1C write coincident with a new match keeps irq=1.
REQ-034 Read 0x0002_0000 -> rdata=0; write to 0x0002_0000 -> no RAM word or register changes.
REQ-035 Assert rst mid-run with GPIO=0x5A and MATCH=1 -> gpio_out, irq, and rdata go to 0 without a clock edge; RAM word 0x10 is retained.

Source files
------------

// File: rtl/rysy_mem_resp.sv
// rysy_mem_resp: single-cycle-latency word RAM plus a GPIO/TIMER/CMP/STATUS register window.
// Reads are unconditional and read-first; writes are byte-masked by be.
module rysy_mem_resp #(
   parameter int                 REG_LEN   = 32,
   parameter int                 MEM_DEPTH = 1024,
   parameter logic [REG_LEN-1:0] IO_BASE   = 32'h0001_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_LEN-1:0] addr,
   input  logic [REG_LEN-1:0] wdata,
   input  logic               we,
   input  logic [3:0]         be,
   output logic [REG_LEN-1:0] rdata,
   output logic [REG_LEN-1:0] gpio_out,
   output logic               irq
);
   localparam int AW = $clog2(MEM_DEPTH);
   logic [REG_LEN-1:0] mem [MEM_DEPTH];
   logic [REG_LEN-1:0] rdata_q, rdata_d, gpio_q, gpio_d, timer_q, timer_d, cmp_q, cmp_d;
   logic [REG_LEN-1:0] wmask, reg_rd;
   logic               match_q, match_d;
   logic               is_ram, is_reg, reg_we, w1c, unused_addr;
   logic [AW-1:0]      widx;
   logic [1:0]         ridx;
   assign unused_addr = ^addr[1:0];
   assign is_ram = addr[REG_LEN-1:12] == '0;
   assign is_reg = addr[REG_LEN-1:4] == IO_BASE[REG_LEN-1:4];
   assign widx   = addr[AW+1:2];
   assign ridx   = addr[3:2];
   assign wmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign reg_we = we && is_reg;
   assign w1c    = reg_we && ridx == 2'd3 && be[0] && wdata[0];
   always_comb begin
      reg_rd  = ridx == 2'd0 ? gpio_q : ridx == 2'd1 ? timer_q : ridx == 2'd2 ? cmp_q :
                {{(REG_LEN-1){1'b0}}, match_q};
      rdata_d = is_ram ? mem[widx] : is_reg ? reg_rd : '0;
      gpio_d  = reg_we && ridx == 2'd0 ? (gpio_q & ~wmask) | (wdata & wmask) : gpio_q;
      cmp_d   = reg_we && ridx == 2'd2 ? (cmp_q & ~wmask) | (wdata & wmask) : cmp_q;
      // a timer write replaces that cycle's increment
      timer_d = reg_we && ridx == 2'd1 && |be ? (timer_q & ~wmask) | (wdata & wmask) : timer_q + 1'b1;
      // a match in the same cycle as a clear wins
      match_d = (timer_q == cmp_q) || (match_q && !w1c);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         gpio_q  <= '0;
         timer_q <= '0;
         cmp_q   <= '1;
         match_q <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         gpio_q  <= gpio_d;
         timer_q <= timer_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
      end
   end
   // RAM has no reset so its contents survive rst
   always_ff @(posedge clk) begin
      if (we && is_ram) mem[widx] <= (mem[widx] & ~wmask) | (wdata & wmask);
   end
   assign rdata    = rdata_q;
   assign gpio_out = gpio_q;
   assign irq      = match_q;
endmodule
